// File: rtl/ex_div_ctrl_if.sv
// Handshake bundle between the execute stage and the ex_div_ctrl divide sequencer.
// The master side is the pipeline, and the slave side is the divider.
interface ex_div_ctrl_if;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        stall_o;
  logic        rd_wen_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  modport master (
    output start_i, funct3_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  stall_o, rd_wen_o, rd_addr_o, rd_data_o
  );

  modport slave (
    input  start_i, funct3_i, op1_i, op2_i, rd_addr_i, flush_i,
    output stall_o, rd_wen_o, rd_addr_o, rd_data_o
  );
endinterface

// File: rtl/ex_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 32-cycle radix-2 restoring division with a one-cycle write-back pulse.
// Optional macro DIV_SPECIAL_BYPASS_EN sends divide-by-zero and signed overflow straight from IDLE to DONE.
module ex_div_ctrl (
  input  logic         clk,
  input  logic         rst,
  ex_div_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [4:0]  count_r;
  logic [31:0] op1_r;
  logic [31:0] op2_r;
  logic [2:0]  funct3_r;
  logic [4:0]  rd_addr_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] div_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        rd_wen_r;
  logic [4:0]  rd_addr_out_r;
  logic [31:0] rd_data_r;

  logic        accept_s;
  logic        signed_s;
  logic [31:0] abs1_s;
  logic [31:0] abs2_s;
  logic [32:0] shift_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;
  logic [31:0] result_s;
`ifdef DIV_SPECIAL_BYPASS_EN
  logic        special_s;
`endif

  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = ~v + 32'd1;
  endfunction

  // Accept decision and operand magnitude and sign preparation
  always_comb begin
    accept_s = (state_r == IDLE) & bus.start_i & ~bus.flush_i;
    signed_s = bus.funct3_i[2] & ~bus.funct3_i[0];
    if (signed_s && bus.op1_i[31]) begin
      abs1_s = neg32(bus.op1_i);
    end else begin
      abs1_s = bus.op1_i;
    end
    if (signed_s && bus.op2_i[31]) begin
      abs2_s = neg32(bus.op2_i);
    end else begin
      abs2_s = bus.op2_i;
    end
`ifdef DIV_SPECIAL_BYPASS_EN
    special_s = (bus.op2_i == 32'd0) |
                (signed_s & (bus.op1_i == 32'h8000_0000) & (bus.op2_i == 32'hFFFF_FFFF));
`endif
  end

  // One restoring-division step; the 33-bit compare covers a shifted remainder past 32 bits
  always_comb begin
    shift_s = {rem_r, quo_r[31]};
    if (shift_s >= {1'b0, div_r}) begin
      rem_next_s = shift_s[31:0] - div_r;
      quo_next_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_next_s = shift_s[31:0];
      quo_next_s = {quo_r[30:0], 1'b0};
    end
  end

  // Sign correction, forced special-case values and final result selection
  always_comb begin
    if (op2_r == 32'd0) begin
      quo_fix_s = 32'hFFFF_FFFF;
      rem_fix_s = op1_r;
    end else if (funct3_r[2] && !funct3_r[0] &&
                 (op1_r == 32'h8000_0000) && (op2_r == 32'hFFFF_FFFF)) begin
      quo_fix_s = 32'h8000_0000;
      rem_fix_s = 32'd0;
    end else begin
      quo_fix_s = neg_q_r ? neg32(quo_r) : quo_r;
      rem_fix_s = neg_r_r ? neg32(rem_r) : rem_r;
    end
    result_s = funct3_r[1] ? rem_fix_s : quo_fix_s;
  end

  // Sequencer FSM with registered write-back outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      count_r       <= 5'd0;
      op1_r         <= 32'd0;
      op2_r         <= 32'd0;
      funct3_r      <= 3'd0;
      rd_addr_r     <= 5'd0;
      rem_r         <= 32'd0;
      quo_r         <= 32'd0;
      div_r         <= 32'd0;
      neg_q_r       <= 1'b0;
      neg_r_r       <= 1'b0;
      rd_wen_r      <= 1'b0;
      rd_addr_out_r <= 5'd0;
      rd_data_r     <= 32'd0;
    end else begin
      rd_wen_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op1_r     <= bus.op1_i;
            op2_r     <= bus.op2_i;
            funct3_r  <= bus.funct3_i;
            rd_addr_r <= bus.rd_addr_i;
            rem_r     <= 32'd0;
            quo_r     <= abs1_s;
            div_r     <= abs2_s;
            neg_q_r   <= signed_s & (bus.op1_i[31] ^ bus.op2_i[31]);
            neg_r_r   <= signed_s & bus.op1_i[31];
            count_r   <= 5'd0;
`ifdef DIV_SPECIAL_BYPASS_EN
            state_r   <= special_s ? DONE : CALC;
`else
            state_r   <= CALC;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (bus.flush_i) begin
            state_r <= IDLE;
          end else begin
            rem_r   <= rem_next_s;
            quo_r   <= quo_next_s;
            count_r <= count_r + 5'd1;
            state_r <= (count_r == 5'd31) ? DONE : CALC;
          end
        end
        DONE: begin
          if (bus.flush_i) begin
            state_r <= IDLE;
          end else begin
            rd_wen_r      <= 1'b1;
            rd_addr_out_r <= rd_addr_r;
            rd_data_r     <= result_s;
            state_r       <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.stall_o   = accept_s | (state_r == CALC);
  assign bus.rd_wen_o  = rd_wen_r;
  assign bus.rd_addr_o = rd_addr_out_r;
  assign bus.rd_data_o = rd_data_r;
endmodule

// File: tb/tb_ex_div_ctrl.sv
// Randomised self-checking bench for ex_div_ctrl against an arithmetic reference of RV32M division.
// Latency expectations follow DIV_SPECIAL_BYPASS_EN when the bench is built with that macro.
module tb_ex_div_ctrl;
  logic clk = 1'b0;
  logic rst;
  ex_div_ctrl_if bus ();

  ex_div_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_data;
  logic [4:0]  last_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
      if (f3[1]) return 32'(sa % sb);
      return 32'(sa / sb);
    end
    if (f3[1]) return a % b;
    return a / b;
  endfunction

  function automatic int op_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_SPECIAL_BYPASS_EN
    if (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  // Issue in the current cycle; returns at the negedge of the write-back cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit junk);
    int lat;
    logic [31:0] exp_v;
    lat   = op_lat(f3, a, b);
    exp_v = ref_div(f3, a, b);
    bus.start_i = 1'b1; bus.funct3_i = f3; bus.op1_i = a; bus.op2_i = b;
    bus.rd_addr_i = rd; bus.flush_i = 1'b0;
    #1 chk("stall_issue", 32'(bus.stall_o), 32'd1);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (junk && k >= 2 && k <= lat - 1) begin
        bus.start_i   = 1'($urandom_range(0, 1));
        bus.op1_i     = $urandom;
        bus.op2_i     = $urandom;
        bus.rd_addr_i = 5'($urandom);
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      chk("stall_busy", 32'(bus.stall_o), 32'(k <= lat - 2));
      if (k < lat) begin
        chk("wen_early", 32'(bus.rd_wen_o), 32'd0);
      end else begin
        chk("wen_pulse", 32'(bus.rd_wen_o), 32'd1);
        chk("rd_data", bus.rd_data_o, exp_v);
        chk("rd_addr", 32'(bus.rd_addr_o), 32'(rd));
      end
    end
    last_data = exp_v;
    last_addr = rd;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      @(negedge clk);
      chk("idle_wen", 32'(bus.rd_wen_o), 32'd0);
      chk("idle_stall", 32'(bus.stall_o), 32'd0);
      chk("hold_data", bus.rd_data_o, last_data);
      chk("hold_addr", 32'(bus.rd_addr_o), 32'(last_addr));
    end
  endtask

  // Start a normal-latency op and flush it in cycle T+kf; no write may follow.
  task automatic flush_op(input int kf);
    bus.start_i = 1'b1; bus.funct3_i = 3'b101; bus.op1_i = 32'd1000; bus.op2_i = 32'd9;
    bus.rd_addr_i = 5'd7; bus.flush_i = 1'b0;
    for (int k = 1; k <= kf + 40; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      bus.flush_i = (k == kf);
      @(negedge clk);
      chk("flush_stall", 32'(bus.stall_o), 32'((k <= kf) && (k <= 32)));
      chk("flush_wen", 32'(bus.rd_wen_o), 32'd0);
      chk("flush_hold", bus.rd_data_o, last_data);
    end
    bus.flush_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.funct3_i = 3'b100; bus.op1_i = 32'd0; bus.op2_i = 32'd0;
    bus.rd_addr_i = 5'd0; bus.flush_i = 1'b0;
    last_data = 32'd0; last_addr = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wen", 32'(bus.rd_wen_o), 32'd0);
    chk("rst_data", bus.rd_data_o, 32'd0);
    chk("rst_addr", 32'(bus.rd_addr_o), 32'd0);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    run_op(3'b101, 32'd100, 32'd7, 5'd3, 1'b0);            idle(2);
    run_op(3'b111, 32'd100, 32'd7, 5'd4, 1'b0);            idle(1);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0);       idle(1);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);       idle(1);
    run_op(3'b100, 32'd5, 32'd0, 5'd8, 1'b0);               idle(1);
    run_op(3'b111, 32'd5, 32'd0, 5'd9, 1'b0);               idle(1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0); idle(1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0); idle(1);
    run_op(3'b100, 32'd77, 32'd3, 5'd0, 1'b1);
    run_op(3'b110, 32'hFFFF_FF00, 32'd7, 5'd31, 1'b1);      idle(1);

    flush_op(11);
    run_op(3'b101, 32'd1000, 32'd9, 5'd12, 1'b0);           idle(1);
    flush_op(33);
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op1_i = 32'd9; bus.op2_i = 32'd3;
    #1 chk("flush_start_stall", 32'(bus.stall_o), 32'd0);
    idle(40);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      run_op(f3, pick(), pick(), 5'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle(1);
    end

    run_op(3'b101, 32'd100, 32'd7, 5'd5, 1'b0);
    bus.start_i = 1'b1; bus.funct3_i = 3'b100; bus.op1_i = 32'd50; bus.op2_i = 32'd5;
    bus.rd_addr_i = 5'd9;
    repeat (15) begin
      @(posedge clk); #1 bus.start_i = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_wen", 32'(bus.rd_wen_o), 32'd0);
    chk("midrst_data", bus.rd_data_o, 32'd0);
    chk("midrst_addr", 32'(bus.rd_addr_o), 32'd0);
    chk("midrst_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    last_data = 32'd0; last_addr = 5'd0;
    idle(40);
    run_op(3'b110, 32'd50, 32'd7, 5'd2, 1'b0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Multi-cycle divide sequencer for the RV32M DIV/DIVU/REM/REMU instructions, placed beside the execute stage. The execute stage forwards a decoded divide and its operands. This block then stalls the front of the pipeline and runs a radix-2 restoring division over 32 cycles. It returns a one-cycle write-back pulse carrying the result and destination register, and handles RISC-V divide-by-zero and signed-overflow semantics.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  divide issued this cycle (opcode INST_TYPE_R_M, funct7 0000001, funct3[2]=1)
- funct3_i  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1_i  input  32  dividend (rs1)
- op2_i  input  32  divisor (rs2)
- rd_addr_i  input  5  destination register
- flush_i  input  1  pipeline flush; aborts any operation in flight
- stall_o  output  1  hold PC, IF/ID and ID/EX
- rd_wen_o  output  1  result valid / register write enable, one-cycle pulse
- rd_addr_o  output  5  destination register for the write
- rd_data_o  output  32  quotient or remainder

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and flush_i=0 latches operands, funct3 and rd_addr.
  - Goes to CALC with count=0.
- Operand preparation:
  - Signed ops (DIV, REM) use absolute values.
  - Record neg_q = sign(op1) XOR sign(op2) and neg_r = sign(op1).
  - Unsigned ops clear both flags.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - If rem >= divisor: subtract divisor and set the quotient LSB.
  - count++.
  - After count 31, go to DONE.
- DONE:
  - Apply sign correction: negate quo if neg_q, negate rem if neg_r.
  - Select quo for DIV/DIVU, rem for REM/REMU.
  - Register the result into rd_data_o, rd_addr_o and rd_wen_o=1.
  - Return to IDLE.
- Special cases, forced at DONE regardless of the datapath:
  - Divisor zero: quotient 0xFFFFFFFF, remainder = op1.
  - DIV/REM with op1=0x80000000 and op2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- stall_o (combinational) = (state==IDLE & start_i & ~flush_i) | (state==CALC). It is deasserted in DONE, so the pipeline advances on the write-back cycle.
- start_i outside IDLE is ignored.
- flush_i in CALC or DONE forces IDLE next cycle and suppresses rd_wen_o.
- flush_i together with start_i in IDLE: flush wins and no operation starts.
- rd_addr=0: the operation runs normally and rd_wen_o still pulses; the register file discards the write.

## Timing
- Reset: state IDLE, count 0, all internal registers 0; rd_wen_o=0, rd_addr_o=0, rd_data_o=0; stall_o=0.
- With start at cycle T, the normal latency is:
  - CALC occupies T+1..T+32.
  - DONE at T+33.
  - rd_wen_o high for exactly the cycle after DONE's edge, i.e. visible during T+34.
  - stall_o high T..T+32 (33 cycles).
- rd_data_o and rd_addr_o hold their last value when rd_wen_o=0.
- Back-to-back operations: the next start_i is accepted in the cycle rd_wen_o is high (state IDLE).
- Reset asserted mid-operation returns to IDLE immediately; no write is produced.

## Configuration
- DIV_SPECIAL_BYPASS_EN:
  - Defined: divisor zero or signed overflow is detected in IDLE, and the FSM goes straight to DONE (stall_o high only at T; rd_wen_o visible T+2).
  - Undefined: special cases run all 32 CALC cycles, with values still forced at DONE.
  - Result values are identical either way; only latency differs.

## Test plan
- DIVU 100/7 at T -> stall_o high T..T+32, rd_wen_o=1 with rd_data_o=14 and rd_addr_o=rd_addr_i at T+34; REMU same operands -> 2.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3); REM same operands -> 0xFFFFFFFF(-1).
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5. With the macro, rd_wen_o at T+2; without, at T+34.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Flush at CALC count 10 -> stall_o drops next cycle, state IDLE, no rd_wen_o pulse; a new start is then accepted and completes correctly.
- rst pulse during CALC -> all outputs 0 immediately, no write; start_i while in CALC is ignored (single rd_wen_o pulse).
